// File: rtl/clk_switch_sequencer_if.sv
// Handshake bundle between the clock-switch sequencer and the DCM / BUFGMUX / phase-shift logic.
// The master modport is the sequencer side; slave is the surrounding clock-management fabric.
interface clk_switch_sequencer_if;
  localparam int unsigned PHASE_W = 9;
  localparam int unsigned STATE_W = 3;

  logic               req_ext_clk_i;
  logic               dcm_locked_i;
  logic               dcm_clkfx_stopped_i;
  logic [PHASE_W-1:0] phase_target_i;
  logic               phase_done_i;
  logic               dcm_reset_o;
  logic               use_ext_clk_o;
  logic               phase_load_o;
  logic [PHASE_W-1:0] phase_value_o;
  logic               clk_ok_o;
  logic               fail_o;
  logic               lock_lost_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  req_ext_clk_i, dcm_locked_i, dcm_clkfx_stopped_i, phase_target_i, phase_done_i,
    output dcm_reset_o, use_ext_clk_o, phase_load_o, phase_value_o, clk_ok_o, fail_o,
           lock_lost_o, state_o
  );

  modport slave (
    output req_ext_clk_i, dcm_locked_i, dcm_clkfx_stopped_i, phase_target_i, phase_done_i,
    input  dcm_reset_o, use_ext_clk_o, phase_load_o, phase_value_o, clk_ok_o, fail_o,
           lock_lost_o, state_o
  );
endinterface

// File: rtl/clk_switch_sequencer.sv
// ADC clock-source switch sequencer: DCM reset, lock wait, phase load, mux flip, lock monitoring
// and bounded retries. Runs on the always-present internal clock.
module clk_switch_sequencer #(
  parameter int unsigned RST_CYCLES    = 3,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input logic                   clk_i,
  input logic                   reset_i,
  clk_switch_sequencer_if.master bus
);
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned PHASE_W = 9;

  localparam logic [2:0] S_INT       = 3'd0;
  localparam logic [2:0] S_DCM_RST   = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_PHASE     = 3'd3;
  localparam logic [2:0] S_SETTLE    = 3'd4;
  localparam logic [2:0] S_EXT       = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               dcm_reset_q, dcm_reset_d;
  logic               use_ext_q, use_ext_d;
  logic               phase_load_q, phase_load_d;
  logic [PHASE_W-1:0] phase_value_q, phase_value_d;
  logic               clk_ok_q, clk_ok_d;
  logic               fail_q, fail_d;
  logic               lock_lost_q, lock_lost_d;
  logic               lock_ok_c;
  logic               retry_go_c;
  logic               withdraw_c;

  assign lock_ok_c  = bus.dcm_locked_i & ~bus.dcm_clkfx_stopped_i;
  assign withdraw_c = ~bus.req_ext_clk_i && (state_q != S_INT) && (state_q != S_FAIL);

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    dcm_reset_d   = dcm_reset_q;
    use_ext_d     = use_ext_q;
    phase_load_d  = 1'b0;
    phase_value_d = phase_value_q;
    clk_ok_d      = clk_ok_q;
    fail_d        = fail_q;
    lock_lost_d   = lock_lost_q;
    retry_go_c    = 1'b0;

    case (state_q)
      S_INT: begin
        retry_d     = '0;
        dcm_reset_d = 1'b1;
        use_ext_d   = 1'b0;
        clk_ok_d    = 1'b1;
        fail_d      = 1'b0;
        if (bus.req_ext_clk_i) begin
          state_d  = S_DCM_RST;
          clk_ok_d = 1'b0;
        end
      end
      S_DCM_RST: begin
        dcm_reset_d = 1'b1;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d     = S_WAIT_LOCK;
          dcm_reset_d = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_ok_c) begin
          state_d       = S_PHASE;
          phase_load_d  = 1'b1;
          phase_value_d = bus.phase_target_i;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_go_c = 1'b1;
        end
      end
      S_PHASE: begin
        // The strobe cycle itself ignores phase_done, which may still show the previous idle level
        if (!lock_ok_c) begin
          retry_go_c = 1'b1;
        end else if (!phase_load_q && bus.phase_done_i) begin
          state_d   = S_SETTLE;
          use_ext_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lock_ok_c) begin
          use_ext_d  = 1'b0;
          retry_go_c = 1'b1;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d  = S_EXT;
          clk_ok_d = 1'b1;
          retry_d  = '0;
        end
      end
      S_EXT: begin
        if (!lock_ok_c) begin
          use_ext_d   = 1'b0;
          clk_ok_d    = 1'b0;
          lock_lost_d = 1'b1;
          retry_go_c  = 1'b1;
        end else if ((bus.phase_target_i != phase_value_q) && bus.phase_done_i && !phase_load_q) begin
          phase_load_d  = 1'b1;
          phase_value_d = bus.phase_target_i;
        end
      end
      S_FAIL: begin
        dcm_reset_d = 1'b1;
        use_ext_d   = 1'b0;
        clk_ok_d    = 1'b1;
        fail_d      = 1'b1;
        if (!bus.req_ext_clk_i) begin
          state_d     = S_INT;
          fail_d      = 1'b0;
          retry_d     = '0;
          lock_lost_d = 1'b0;
        end
      end
      default: state_d = S_INT;
    endcase

    if (retry_go_c) begin
      dcm_reset_d = 1'b1;
      if (retry_q < RETRY_W'(MAX_RETRIES)) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = S_DCM_RST;
      end else begin
        state_d   = S_FAIL;
        use_ext_d = 1'b0;
        clk_ok_d  = 1'b1;
        fail_d    = 1'b1;
      end
    end

    // Withdrawal outranks lock loss and timeout; any pending phase load is dropped
    if (withdraw_c) begin
      state_d       = S_INT;
      retry_d       = '0;
      dcm_reset_d   = 1'b1;
      use_ext_d     = 1'b0;
      phase_load_d  = 1'b0;
      phase_value_d = phase_value_q;
      clk_ok_d      = 1'b1;
      fail_d        = 1'b0;
      lock_lost_d   = 1'b0;
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_INT;
      cnt_q         <= '0;
      retry_q       <= '0;
      dcm_reset_q   <= 1'b1;
      use_ext_q     <= 1'b0;
      phase_load_q  <= 1'b0;
      phase_value_q <= '0;
      clk_ok_q      <= 1'b1;
      fail_q        <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      dcm_reset_q   <= dcm_reset_d;
      use_ext_q     <= use_ext_d;
      phase_load_q  <= phase_load_d;
      phase_value_q <= phase_value_d;
      clk_ok_q      <= clk_ok_d;
      fail_q        <= fail_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign bus.state_o       = state_q;
  assign bus.dcm_reset_o   = dcm_reset_q;
  assign bus.use_ext_clk_o = use_ext_q;
  assign bus.phase_load_o  = phase_load_q;
  assign bus.phase_value_o = phase_value_q;
  assign bus.clk_ok_o      = clk_ok_q;
  assign bus.fail_o        = fail_q;
  assign bus.lock_lost_o   = lock_lost_q;
endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Directed bench for clk_switch_sequencer: happy path, retune, lock loss, withdrawal,
// mid-sequence reset and timeout-to-FAIL, with hand-computed cycle counts.
module tb_clk_switch_sequencer;
  localparam logic [2:0] S_INT       = 3'd0;
  localparam logic [2:0] S_DCM_RST   = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_PHASE     = 3'd3;
  localparam logic [2:0] S_SETTLE    = 3'd4;
  localparam logic [2:0] S_EXT       = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic prev_load = 1'b0;

  clk_switch_sequencer_if bus ();

  clk_switch_sequencer #(
    .RST_CYCLES   (3),
    .LOCK_TIMEOUT (100),
    .SETTLE_CYCLES(16),
    .MAX_RETRIES  (3)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Continuous invariants: mux select tracks SETTLE/EXT, load strobe never back-to-back
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("use_ext_state", 32'(bus.use_ext_clk_o),
            32'((bus.state_o == S_SETTLE) || (bus.state_o == S_EXT)));
      if (prev_load) check("load_twice", 32'(bus.phase_load_o), 32'd0);
      prev_load = bus.phase_load_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int entries;
    logic [2:0] prev;

    reset_i                 = 1'b1;
    bus.req_ext_clk_i       = 1'b0;
    bus.dcm_locked_i        = 1'b0;
    bus.dcm_clkfx_stopped_i = 1'b0;
    bus.phase_target_i      = 9'd0;
    bus.phase_done_i        = 1'b1;
    step(2);
    check("rst_state", 32'(bus.state_o), 32'(S_INT));
    check("rst_dcm_reset", 32'(bus.dcm_reset_o), 32'd1);
    check("rst_use_ext", 32'(bus.use_ext_clk_o), 32'd0);
    check("rst_load", 32'(bus.phase_load_o), 32'd0);
    check("rst_value", 32'(bus.phase_value_o), 32'd0);
    check("rst_clk_ok", 32'(bus.clk_ok_o), 32'd1);
    check("rst_fail", 32'(bus.fail_o), 32'd0);
    check("rst_lost", 32'(bus.lock_lost_o), 32'd0);
    reset_i = 1'b0;
    mon_en  = 1'b1;
    step(1);
    check("idle_int", 32'(bus.state_o), 32'(S_INT));

    // Happy path
    bus.phase_target_i = 9'd37;
    bus.phase_done_i   = 1'b0;
    bus.req_ext_clk_i  = 1'b1;
    step(1);
    check("req_state", 32'(bus.state_o), 32'(S_DCM_RST));
    check("req_dcm_reset", 32'(bus.dcm_reset_o), 32'd1);
    check("req_clk_ok", 32'(bus.clk_ok_o), 32'd0);
    n = 0;
    while (bus.state_o == S_DCM_RST && n < 10) begin n++; step(1); end
    check("rst_cycles", 32'(n), 32'd3);
    check("wait_state", 32'(bus.state_o), 32'(S_WAIT_LOCK));
    check("wait_dcm_reset", 32'(bus.dcm_reset_o), 32'd0);
    step(20);
    check("wait_hold", 32'(bus.state_o), 32'(S_WAIT_LOCK));
    bus.dcm_locked_i = 1'b1;
    step(1);
    check("phase_state", 32'(bus.state_o), 32'(S_PHASE));
    check("phase_load", 32'(bus.phase_load_o), 32'd1);
    check("phase_value", 32'(bus.phase_value_o), 32'd37);
    step(1);
    check("phase_load_low", 32'(bus.phase_load_o), 32'd0);
    step(3);
    check("phase_busy", 32'(bus.state_o), 32'(S_PHASE));
    bus.phase_done_i = 1'b1;
    step(1);
    check("settle_state", 32'(bus.state_o), 32'(S_SETTLE));
    check("settle_use_ext", 32'(bus.use_ext_clk_o), 32'd1);
    check("settle_clk_ok", 32'(bus.clk_ok_o), 32'd0);
    n = 0;
    while (!bus.clk_ok_o && n < 40) begin n++; step(1); end
    check("settle_cycles", 32'(n), 32'd16);
    check("ext_state", 32'(bus.state_o), 32'(S_EXT));
    check("ext_use_ext", 32'(bus.use_ext_clk_o), 32'd1);

    // Phase retune while busy, then done
    bus.phase_done_i   = 1'b0;
    bus.phase_target_i = 9'd200;
    step(3);
    check("retune_busy_load", 32'(bus.phase_load_o), 32'd0);
    check("retune_busy_value", 32'(bus.phase_value_o), 32'd37);
    check("retune_busy_ok", 32'(bus.clk_ok_o), 32'd1);
    bus.phase_done_i = 1'b1;
    step(1);
    check("retune_load", 32'(bus.phase_load_o), 32'd1);
    check("retune_value", 32'(bus.phase_value_o), 32'd200);
    check("retune_ok", 32'(bus.clk_ok_o), 32'd1);
    step(1);
    check("retune_single", 32'(bus.phase_load_o), 32'd0);
    check("retune_state", 32'(bus.state_o), 32'(S_EXT));

    // One-cycle lock loss in EXT, then full re-sequence
    bus.dcm_locked_i = 1'b0;
    step(1);
    bus.dcm_locked_i = 1'b1;
    check("loss_state", 32'(bus.state_o), 32'(S_DCM_RST));
    check("loss_use_ext", 32'(bus.use_ext_clk_o), 32'd0);
    check("loss_clk_ok", 32'(bus.clk_ok_o), 32'd0);
    check("loss_lost", 32'(bus.lock_lost_o), 32'd1);
    n = 0;
    while (bus.state_o != S_EXT && n < 60) begin n++; step(1); end
    check("reseq_cycles", 32'(n), 32'd22);
    check("reseq_lost", 32'(bus.lock_lost_o), 32'd1);
    check("reseq_clk_ok", 32'(bus.clk_ok_o), 32'd1);

    // Withdrawal coinciding with lock loss in SETTLE
    bus.dcm_locked_i = 1'b0;
    step(1);
    bus.dcm_locked_i = 1'b1;
    n = 0;
    while (bus.state_o != S_SETTLE && n < 30) begin n++; step(1); end
    check("to_settle_cycles", 32'(n), 32'd6);
    bus.req_ext_clk_i = 1'b0;
    bus.dcm_locked_i  = 1'b0;
    step(1);
    check("wd_state", 32'(bus.state_o), 32'(S_INT));
    check("wd_lost", 32'(bus.lock_lost_o), 32'd0);
    check("wd_dcm_reset", 32'(bus.dcm_reset_o), 32'd1);
    check("wd_clk_ok", 32'(bus.clk_ok_o), 32'd1);
    step(1);
    check("wd_stay", 32'(bus.state_o), 32'(S_INT));

    // Reset asserted during WAIT_LOCK
    bus.req_ext_clk_i = 1'b1;
    step(1);
    step(3);
    check("mid_wait", 32'(bus.state_o), 32'(S_WAIT_LOCK));
    reset_i = 1'b1;
    step(1);
    check("mid_state", 32'(bus.state_o), 32'(S_INT));
    check("mid_dcm_reset", 32'(bus.dcm_reset_o), 32'd1);
    check("mid_use_ext", 32'(bus.use_ext_clk_o), 32'd0);
    check("mid_load", 32'(bus.phase_load_o), 32'd0);
    check("mid_value", 32'(bus.phase_value_o), 32'd0);
    check("mid_clk_ok", 32'(bus.clk_ok_o), 32'd1);
    check("mid_fail", 32'(bus.fail_o), 32'd0);
    check("mid_lost", 32'(bus.lock_lost_o), 32'd0);
    reset_i = 1'b0;

    // Never lock: 4 attempts of 3 + 100 cycles each, then FAIL
    prev    = bus.state_o;
    n       = 0;
    entries = 0;
    while (bus.state_o != S_FAIL && n < 1000) begin
      step(1);
      n++;
      if (bus.state_o == S_DCM_RST && prev != S_DCM_RST) entries++;
      prev = bus.state_o;
    end
    check("fail_entries", 32'(entries), 32'd4);
    check("fail_cycles", 32'(n), 32'd413);
    check("fail_flag", 32'(bus.fail_o), 32'd1);
    check("fail_use_ext", 32'(bus.use_ext_clk_o), 32'd0);
    check("fail_clk_ok", 32'(bus.clk_ok_o), 32'd1);
    check("fail_dcm_reset", 32'(bus.dcm_reset_o), 32'd1);
    step(2);
    check("fail_hold", 32'(bus.state_o), 32'(S_FAIL));
    bus.req_ext_clk_i = 1'b0;
    step(1);
    check("fail_exit_state", 32'(bus.state_o), 32'(S_INT));
    check("fail_exit_flag", 32'(bus.fail_o), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
